mult_wallace_pipe: RTL

Parametrised, pipelined Wallace-tree multiplier with a valid/ready stream interface and per-transaction signed/unsigned mode. It is the successor to the fixed 8x8 combinational Wallace multiplier in the Synthetic benchmark set. It generalises operand widths and pipeline depth, and adds backpressure and two's-complement operation. It sits on a datapath stream between an operand producer and a result consumer, one product per cycle at full throughput.

---
 rtl/mult_wallace_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mult_wallace_pipe.sv
`timescale 1ns/1ps
// Pipelined Wallace-tree multiplier with a valid/ready stream interface.
// Signed mode uses Baugh-Wooley partial products; the whole pipeline stalls together.
module mult_wallace_pipe #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 8,
  parameter int STAGES  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  input  logic                       signed_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] product,
  output logic                       busy
);

  localparam int W  = WIDTH_A + WIDTH_B;
  localparam int NR = WIDTH_B + 1;
  localparam int NP = (STAGES > 1) ? STAGES - 1 : 1;

  typedef logic [NR-1:0][W-1:0] rows_t;

  function automatic int rows_at(input int l);
    int n = NR;
    for (int i = 0; i < l; i++) n = 2 * (n / 3) + n % 3;
    return n;
  endfunction

  function automatic int num_layers();
    int n = NR;
    int l = 0;
    for (int i = 0; i < 64; i++) begin
      if (n > 2) begin
        n = 2 * (n / 3) + n % 3;
        l++;
      end
    end
    return l;
  endfunction

  localparam int NL = num_layers();

  // Layer boundary after which pipeline register s (1..STAGES-1) sits.
  function automatic int cut(input int s);
    return (s * NL) / STAGES;
  endfunction

  // One Wallace layer: each full group of three rows goes through a row of
  // 3:2 counters; leftover rows pass straight through to the next layer.
  function automatic rows_t csa_layer(input rows_t x, input int n);
    rows_t y;
    logic [W-1:0] maj;
    y = '0;
    for (int g = 0; g < NR / 3; g++) begin
      if (3 * g + 2 < n) begin
        maj = (x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) | (x[3*g+1] & x[3*g+2]);
        y[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
        y[2*g+1] = {maj[W-2:0], 1'b0};
      end
    end
    for (int r = 0; r < NR; r++) begin
      if (r >= 3 * (n / 3) && r < n) y[2 * (n / 3) + r - 3 * (n / 3)] = x[r];
    end
    return y;
  endfunction

  // Baugh-Wooley correction: 2^(WA-1) + 2^(WB-1) + 2^(W-1).
  localparam logic [W-1:0] BW_FIX = (W'(1) << (WIDTH_A - 1)) + (W'(1) << (WIDTH_B - 1))
                                  + (W'(1) << (W - 1));

  // Stream handshake: a beat moves on an edge where valid && ready. Every stage
  // shifts when the output register is empty or being drained, so in_ready is
  // exactly that advance condition and a stall freezes bubbles too.
  logic              advance;
  logic [STAGES-1:0] vld_q;
  rows_t             pp;
  rows_t             cur;
  rows_t             st_d [NP];
  rows_t             st_q [NP];
  logic [W-1:0]      sum_d;

  assign out_valid = vld_q[STAGES-1];
  assign busy      = |vld_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH_B; i++) begin
      for (int j = 0; j < WIDTH_A; j++) begin
        pp[i][i+j] = (a[j] & b[i]) ^ (signed_mode && ((i == WIDTH_B - 1) != (j == WIDTH_A - 1)));
      end
    end
    pp[WIDTH_B] = signed_mode ? BW_FIX : '0;
  end

  // Walk the layers; at each register boundary capture the running value and
  // continue from the register output instead.
  always_comb begin
    cur = pp;
    for (int k = 0; k < NP; k++) st_d[k] = '0;
    for (int l = 0; l <= NL; l++) begin
      for (int s = 1; s < STAGES; s++) begin
        if (cut(s) == l) begin
          st_d[s-1] = cur;
          cur       = st_q[s-1];
        end
      end
      if (l < NL) cur = csa_layer(cur, rows_at(l));
    end
    sum_d = cur[0] + cur[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      product <= '0;
      for (int k = 0; k < NP; k++) st_q[k] <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_q[k] <= vld_q[k-1];
      for (int k = 0; k < STAGES - 1; k++) st_q[k] <= st_d[k];
      product <= sum_d;
    end
  end

endmodule
